// File: rtl/stack_ctrl.sv
// Request/response controller for a 4-deep, 18-bit LIFO: sequences push and pop strobes and tracks occupancy.
// Optional macro STACK_CTRL_STICKY_ERR_EN makes the overflow/underflow flags sticky until reset.
module stack_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_op,
    input  logic [17:0] req_data,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [17:0] rsp_data,
    input  logic        rsp_ready,
    output logic [2:0]  depth,
    output logic        err_overflow,
    output logic        err_underflow,
    output logic        write_stack_en,
    output logic        read_stack_en,
    output logic [17:0] in_stack_data,
    input  logic [17:0] out_stack_data
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PUSH = 3'd1,
        POP  = 3'd2,
        CAPT = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic [2:0] MAX_DEPTH = 3'd4;

    state_t      r_state;
    logic [2:0]  r_depth;
    logic [17:0] r_rsp_data;
    logic [17:0] r_in_data;
    logic        r_err_ov;
    logic        r_err_un;
    logic        r_wr_en;
    logic        r_rd_en;
    logic        r_rsp_valid;
    logic        r_req_ready;

    // Strobes and handshakes are registered together with the state so each
    // output is high exactly while the matching state is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_depth     <= 3'd0;
            r_rsp_data  <= 18'd0;
            r_in_data   <= 18'd0;
            r_err_ov    <= 1'b0;
            r_err_un    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
`ifndef STACK_CTRL_STICKY_ERR_EN
            r_err_ov <= 1'b0;
            r_err_un <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (!req_op) begin
                            if (r_depth != MAX_DEPTH) begin
                                r_in_data   <= req_data;
                                r_depth     <= r_depth + 3'd1;
                                r_state     <= PUSH;
                                r_wr_en     <= 1'b1;
                                r_req_ready <= 1'b0;
                            end else begin
                                r_err_ov <= 1'b1;
                            end
                        end else begin
                            if (r_depth != 3'd0) begin
                                r_depth     <= r_depth - 3'd1;
                                r_state     <= POP;
                                r_rd_en     <= 1'b1;
                                r_req_ready <= 1'b0;
                            end else begin
                                r_err_un <= 1'b1;
                            end
                        end
                    end
                end
                PUSH: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
                POP: begin
                    r_state <= CAPT;
                end
                CAPT: begin
                    // The stack's registered output is valid during this cycle.
                    r_rsp_data  <= out_stack_data;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign depth          = r_depth;
    assign err_overflow   = r_err_ov;
    assign err_underflow  = r_err_un;
    assign write_stack_en = r_wr_en;
    assign read_stack_en  = r_rd_en;
    assign in_stack_data  = r_in_data;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: emulates the downstream LIFO and compares against a queue-based model.
// Honours STACK_CTRL_STICKY_ERR_EN for the expected error-flag behaviour.
module tb_stack_ctrl;

`ifdef STACK_CTRL_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_op;
    logic [17:0] req_data;
    logic        req_ready;
    logic        rsp_valid;
    logic [17:0] rsp_data;
    logic        rsp_ready;
    logic [2:0]  depth;
    logic        err_overflow;
    logic        err_underflow;
    logic        write_stack_en;
    logic        read_stack_en;
    logic [17:0] in_stack_data;
    logic [17:0] out_stack_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [17:0] ref_q[$];
    bit          ov_seen;
    bit          un_seen;

    always #5 clk = ~clk;

    stack_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_ready      (rsp_ready),
        .depth          (depth),
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow),
        .write_stack_en (write_stack_en),
        .read_stack_en  (read_stack_en),
        .in_stack_data  (in_stack_data),
        .out_stack_data (out_stack_data)
    );

    // Downstream 4-deep stack with registered output, reset by the shared net.
    logic [17:0] stk_mem [4];
    logic [2:0]  stk_sp;
    always @(posedge clk) begin
        if (rst) begin
            stk_sp         <= 3'd0;
            out_stack_data <= 18'd0;
        end else if (write_stack_en && stk_sp < 3'd4) begin
            stk_mem[stk_sp[1:0]] <= in_stack_data;
            stk_sp               <= stk_sp + 3'd1;
        end else if (read_stack_en && stk_sp > 3'd0) begin
            out_stack_data <= stk_mem[stk_sp[1:0] - 2'd1];
            stk_sp         <= stk_sp - 3'd1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0)
            check_val("strobe_excl", {31'd0, write_stack_en & read_stack_en}, 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        ref_q.delete();
        ov_seen = 1'b0;
        un_seen = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_model();
        check_val("rst_ready", req_ready, 1);
        check_val("rst_depth", depth, 0);
        check_val("rst_rspv", rsp_valid, 0);
        check_val("rst_wr", write_stack_en, 0);
        check_val("rst_rd", read_stack_en, 0);
        check_val("rst_rspd", rsp_data, 0);
        check_val("rst_ind", in_stack_data, 0);
        check_val("rst_ov", err_overflow, 0);
        check_val("rst_un", err_underflow, 0);
        $display("reset done");
    endtask

    task automatic do_push(input logic [17:0] d);
        bit full;
        full = (ref_q.size() == 4);
        check_val("push_rdy", req_ready, 1);
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_data  = d;
        tick();
        req_valid = 1'b0;
        req_data  = ~d;
        if (!full) begin
            ref_q.push_back(d);
            check_val("push_wr", write_stack_en, 1);
            check_val("push_rd", read_stack_en, 0);
            check_val("push_data", in_stack_data, d);
            check_val("push_depth", depth, ref_q.size());
            check_val("push_busy", req_ready, 0);
            check_val("push_ov", err_overflow, STICKY & ov_seen);
            tick();
            check_val("push_wr_end", write_stack_en, 0);
            check_val("push_idle", req_ready, 1);
            $display("push %05h ok depth=%0d", d, depth);
        end else begin
            ov_seen = 1'b1;
            check_val("ovf_wr", write_stack_en, 0);
            check_val("ovf_depth", depth, 4);
            check_val("ovf_flag", err_overflow, 1);
            check_val("ovf_rdy", req_ready, 1);
            tick();
            check_val("ovf_wr2", write_stack_en, 0);
            check_val("ovf_flag2", err_overflow, STICKY);
            check_val("ovf_depth2", depth, 4);
            $display("push %05h rejected (full) err_overflow", d);
        end
    endtask

    // wait_cyc = number of RESP cycles with rsp_ready held low.
    task automatic do_pop(input int wait_cyc);
        logic [17:0] exp;
        check_val("pop_rdy", req_ready, 1);
        rsp_ready = (wait_cyc == 0);
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_data  = 18'($urandom);
        tick();
        req_valid = 1'b0;
        req_op    = 1'b0;
        if (ref_q.size() == 0) begin
            un_seen = 1'b1;
            check_val("unf_rd", read_stack_en, 0);
            check_val("unf_depth", depth, 0);
            check_val("unf_flag", err_underflow, 1);
            check_val("unf_rdy", req_ready, 1);
            tick();
            check_val("unf_rd2", read_stack_en, 0);
            check_val("unf_flag2", err_underflow, STICKY);
            check_val("unf_rdy2", req_ready, 1);
            $display("pop rejected (empty) err_underflow");
        end else begin
            exp = ref_q.pop_back();
            check_val("pop_rd", read_stack_en, 1);
            check_val("pop_wr", write_stack_en, 0);
            check_val("pop_depth", depth, ref_q.size());
            check_val("pop_busy", req_ready, 0);
            check_val("pop_rspv0", rsp_valid, 0);
            tick();
            check_val("capt_rd", read_stack_en, 0);
            check_val("capt_rspv", rsp_valid, 0);
            tick();
            check_val("resp_valid", rsp_valid, 1);
            check_val("resp_data", rsp_data, exp);
            check_val("resp_busy", req_ready, 0);
            for (int i = 1; i < wait_cyc; i++) begin
                tick();
                check_val("hold_valid", rsp_valid, 1);
                check_val("hold_data", rsp_data, exp);
                check_val("hold_busy", req_ready, 0);
            end
            rsp_ready = 1'b1;
            tick();
            check_val("resp_done", rsp_valid, 0);
            check_val("resp_idle", req_ready, 1);
            $display("pop %05h ok depth=%0d wait=%0d", exp, depth, wait_cyc);
        end
    endtask

    task automatic do_reset_in_pop();
        do_push(18'h2A5A5);
        req_valid = 1'b1;
        req_op    = 1'b1;
        tick();
        req_valid = 1'b0;
        check_val("rip_rd", read_stack_en, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        check_val("rip_rspv", rsp_valid, 0);
        check_val("rip_depth", depth, 0);
        check_val("rip_rdy", req_ready, 1);
        check_val("rip_rd2", read_stack_en, 0);
        check_val("rip_wr", write_stack_en, 0);
        tick();
        check_val("rip_rspv2", rsp_valid, 0);
        check_val("rip_rdy2", req_ready, 1);
        $display("reset during POP: operation discarded");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [17:0] rnd;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_data  = 18'd0;
        rsp_ready = 1'b1;
        clear_model();
        do_reset();

        do_push(18'h00011);
        do_push(18'h00022);
        do_push(18'h00033);
        check_val("three_depth", depth, 3);
        do_pop(0);
        do_pop(2);
        do_pop(1);
        do_pop(0);

        for (int i = 0; i < 4; i++) begin
            rnd = 18'($urandom);
            do_push(rnd);
        end
        do_push(18'h3FFFF);
        do_push(18'h3FFFF);

        do_reset();
        do_push(18'h1234A);
        do_push(18'h0BEEF);
        do_pop(5);
        do_reset_in_pop();

        for (int i = 0; i < 120; i++) begin
            rnd = 18'($urandom);
            if ($urandom_range(0, 1) == 0)
                do_push(rnd);
            else
                do_pop(int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset; the same net also resets the downstream stack.
REQ-003 SHALL have port req_valid  input  1  upstream request present.
REQ-004 SHALL have port req_op  input  1  operation select: 0 = push, 1 = pop.
REQ-005 SHALL have port req_data  input  18  push operand.
REQ-006 SHALL have port req_ready  output  1  controller can accept a request; high exactly when state = IDLE.
REQ-007 SHALL have port rsp_valid  output  1  popped word available on rsp_data.
REQ-008 SHALL have port rsp_data  output  18  popped word.
REQ-009 SHALL have port rsp_ready  input  1  upstream consumes the response.
REQ-010 SHALL have port depth  output  3  stack occupancy, 0..4.
REQ-011 SHALL have port err_overflow  output  1  push rejected because the stack is full.
REQ-012 SHALL have port err_underflow  output  1  pop rejected because the stack is empty.
REQ-013 SHALL have port write_stack_en  output  1  push strobe to the 4-deep, 18-bit stack.
REQ-014 SHALL have port read_stack_en  output  1  pop strobe to the stack.
REQ-015 SHALL have port in_stack_data  output  18  word presented to the stack.
REQ-016 SHALL have port out_stack_data  input  18  registered stack output; valid one cycle after the read_stack_en cycle.

Function
REQ-017 SHALL implement states IDLE, PUSH, POP, CAPT and RESP.
REQ-018 SHALL accept a request on any edge where req_valid=1 and state=IDLE.
REQ-019 On an accepted push with depth<4, SHALL register req_data into in_stack_data, increment depth and go to PUSH.
REQ-020 In PUSH, SHALL drive write_stack_en=1 for exactly one cycle and then return to IDLE; push throughput is one per 2 cycles.
REQ-021 On an accepted pop with depth>0, SHALL decrement depth and go to POP.
REQ-022 In POP, SHALL drive read_stack_en=1 for exactly one cycle and then go to CAPT.
REQ-023 In CAPT, SHALL register out_stack_data into rsp_data and then go to RESP.
REQ-024 In RESP, SHALL hold rsp_valid=1 and keep rsp_data stable until rsp_ready=1; on that edge it SHALL return to IDLE.
REQ-025 Pop latency SHALL be: rsp_valid first high 3 cycles after the acceptance edge.
REQ-026 An accepted push with depth=4 SHALL be consumed, stay in IDLE, not assert write_stack_en, leave depth unchanged, and set err_overflow on the next edge.
REQ-027 An accepted pop with depth=0 SHALL be consumed, stay in IDLE, not assert read_stack_en, leave depth unchanged, and set err_underflow on the next edge.
REQ-028 write_stack_en and read_stack_en SHALL never be high in the same cycle, and neither SHALL be high outside PUSH or POP respectively.
REQ-029 depth SHALL never exceed 4 and SHALL never wrap below 0.
REQ-030 Inputs req_op and req_data SHALL be ignored when not in IDLE.

Reset
REQ-031 With rst=1 at an edge, the block SHALL go to IDLE and clear depth, rsp_data, in_stack_data, err_overflow and err_underflow to 0.
REQ-032 After reset, write_stack_en, read_stack_en and rsp_valid SHALL be 0 and req_ready SHALL be 1.
REQ-033 Reset SHALL override any in-flight PUSH, POP, CAPT or RESP, and the in-flight operation SHALL be discarded with no strobe issued on the following cycle.

Configuration
REQ-034 When STACK_CTRL_STICKY_ERR_EN is defined, err_overflow and err_underflow SHALL stay set once set, until rst.
REQ-035 When STACK_CTRL_STICKY_ERR_EN is undefined, each error flag SHALL be a single-cycle pulse, high for the one cycle after the rejected request.

Verification
REQ-036 Bench SHALL cover: reset, then push 0x00011, 0x00022 and 0x00033 -> write_stack_en pulses three times, in_stack_data matches each value, depth=3.
REQ-037 Bench SHALL cover: from that state, pop with rsp_ready=1 -> read_stack_en one cycle, rsp_valid 3 cycles after acceptance, rsp_data=0x00033, depth=2.
REQ-038 Bench SHALL cover: 4 pushes followed by a 5th push of 0x3FFFF -> no 5th write_stack_en, depth stays 4, err_overflow set (pulse or sticky per macro).
REQ-039 Bench SHALL cover: pop on an empty stack -> no read_stack_en, depth=0, err_underflow set, req_ready=1 on the next cycle.
REQ-040 Bench SHALL cover: pop with rsp_ready held at 0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout, return to IDLE on the edge where rsp_ready=1.
REQ-041 Bench SHALL cover: rst asserted during POP -> no CAPT, rsp_valid stays 0, depth=0, req_ready=1 after the reset edge.
